// File: rtl/ppu_vga_pkg.sv
// Shared definitions for the NES-to-VGA scan doubler.
// Holds the default VGA 640x480 timing, the NES picture geometry and the
// pixel types exchanged between the scaler top and its colour LUT.
package ppu_vga_pkg;

    // Default 640x480@60 timing, counted in VGA pixels / lines.
    localparam int VGA_H_VIS    = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_VIS    = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;
    localparam int VGA_H_OFFSET = 64;

    // NES picture geometry.
    localparam int NES_W = 256;
    localparam int NES_H = 240;

    typedef logic [5:0] nes_color_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

endpackage

// File: rtl/nes_rgb_lut.sv
// NES master palette lookup.
// Converts a 6-bit NES colour index into 24-bit RGB with one registered
// stage that only advances on pix_tick, so it stays in step with scan-out.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   pix_tick    VGA pixel enable
//   color_idx   NES colour index (0..63)
//   rgb         registered RGB for the index seen on the previous pix_tick
module nes_rgb_lut
    import ppu_vga_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pix_tick,
    input  nes_color_t color_idx,
    output rgb_t       rgb
);

    // Standard NES palette; the unused "black" slots at 0x0D-0x0F,
    // 0x1D-0x1F, 0x2E-0x2F and 0x3E-0x3F are forced to 000000.
    localparam logic [23:0] PALETTE [64] = '{
        24'h7C7C7C, 24'h0000FC, 24'h0000BC, 24'h4428BC, 24'h940084, 24'hA80020, 24'hA81000, 24'h881400,
        24'h503000, 24'h007800, 24'h006800, 24'h005800, 24'h004058, 24'h000000, 24'h000000, 24'h000000,
        24'hBCBCBC, 24'h0078F8, 24'h0058F8, 24'h6844FC, 24'hD800CC, 24'hE40058, 24'hF83800, 24'hE45C10,
        24'hAC7C00, 24'h00B800, 24'h00A800, 24'h00A844, 24'h008888, 24'h000000, 24'h000000, 24'h000000,
        24'hF8F8F8, 24'h3CBCFC, 24'h6888FC, 24'h9878F8, 24'hF878F8, 24'hF85898, 24'hF87858, 24'hFCA044,
        24'hF8B800, 24'hB8F818, 24'h58D854, 24'h58F898, 24'h00E8D8, 24'h787878, 24'h000000, 24'h000000,
        24'hFCFCFC, 24'hA4E4FC, 24'hB8B8F8, 24'hD8B8F8, 24'hF8B8F8, 24'hF8A4C0, 24'hF0D0B0, 24'hFCE0A8,
        24'hF8D878, 24'hD8F878, 24'hB8F8B8, 24'hB8F8D8, 24'h00FCFC, 24'hF8D8F8, 24'h000000, 24'h000000
    };

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb <= '0;
        end else if (pix_tick) begin
            rgb <= rgb_t'(PALETTE[color_idx]);
        end
    end

endmodule

// File: rtl/ppu_vga_scaler.sv
// NES PPU to VGA 640x480 scan doubler.
// The PPU writes one 256-pixel line at a time into a pair of ping-pong line
// buffers (selected by the NES row's LSB). Scan-out reads each NES line for
// two VGA lines, doubles every pixel horizontally, centres the 512-pixel
// picture between 64-pixel black borders and converts through the palette.
// Scan-out pipeline, all stages advancing on pix_tick:
//   tick t   : counter decode, line-buffer read registered
//   tick t+1 : palette LUT registered (RGB at pins, masked by border/blank)
// Sync, blank and border flags ride a matching 2-tick delay line, so every
// pin shows the pixel the counters pointed at two pix_ticks earlier.
// Write strobe: ppu_pix_valid is a one-cycle write enable with no back
// pressure; an asserted strobe with an in-range row is always committed on
// that clk, whether or not pix_tick is high.
// Ports:
//   clk, rst_n           clock and asynchronous active-low reset
//   pix_tick             VGA pixel enable
//   ppu_pix_valid/x/y    PPU pixel write strobe and NES coordinates
//   ppu_color            palette colour index of the written pixel
//   line_req/line_req_y  one-clk request for the PPU to render a NES line
//   frame_start          one-clk pulse at the VGA frame origin
//   vga_r/g/b            RGB, zero outside the picture
//   vga_hs/vs            sync, active low
//   vga_blank            high outside the 640x480 active area
module ppu_vga_scaler
    import ppu_vga_pkg::*;
#(
    parameter int H_VIS    = VGA_H_VIS,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_VIS    = VGA_V_VIS,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP,
    parameter int H_OFFSET = VGA_H_OFFSET
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pix_tick,
    input  logic       ppu_pix_valid,
    input  logic [7:0] ppu_pix_x,
    input  logic [7:0] ppu_pix_y,
    input  logic [5:0] ppu_color,
    output logic       line_req,
    output logic [7:0] line_req_y,
    output logic       frame_start,
    output logic [7:0] vga_r,
    output logic [7:0] vga_g,
    output logic [7:0] vga_b,
    output logic       vga_hs,
    output logic       vga_vs,
    output logic       vga_blank
);

    localparam int H_TOT     = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT     = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int H_PIC_END = H_OFFSET + 2 * NES_W;

    // ---------------- scan counters ----------------
    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic       h_last;
    logic       v_last;

    assign h_last = (h_cnt == 10'(H_TOT - 1));
    assign v_last = (v_cnt == 10'(V_TOT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_tick) begin
            if (h_last) begin
                h_cnt <= '0;
                v_cnt <= v_last ? 10'd0 : v_cnt + 10'd1;
            end else begin
                h_cnt <= h_cnt + 10'd1;
            end
        end
    end

    // ---------------- stage 1 decode ----------------
    logic       active;
    logic       in_pic;
    logic       hs_pre;
    logic       vs_pre;
    logic [7:0] rd_col;
    logic [8:0] rd_addr;

    always_comb begin
        active  = (h_cnt < 10'(H_VIS)) && (v_cnt < 10'(V_VIS));
        in_pic  = (h_cnt >= 10'(H_OFFSET)) && (h_cnt < 10'(H_PIC_END));
        hs_pre  = !((h_cnt >= 10'(H_VIS + H_FP)) && (h_cnt < 10'(H_VIS + H_FP + H_SYNC)));
        vs_pre  = !((v_cnt >= 10'(V_VIS + V_FP)) && (v_cnt < 10'(V_VIS + V_FP + V_SYNC)));
        // Dividing the in-picture offset by two doubles each NES pixel.
        // Outside the picture the address is junk but the pixel is masked.
        rd_col  = 8'((h_cnt - 10'(H_OFFSET)) >> 1);
        // NES line is v_cnt>>1, so its LSB (v_cnt[1]) picks the buffer.
        rd_addr = {v_cnt[1], rd_col};
    end

    // ---------------- ping-pong line buffers ----------------
    // Buffer contents are deliberately not reset. A read and write of the
    // same entry in one clk returns the old value; the write still lands.
    nes_color_t line_buf [0:2*NES_W-1];
    nes_color_t rd_data;
    logic       wr_en;

    // ppu_pix_x is 8 bits, so only the row needs a range check.
    assign wr_en = ppu_pix_valid && (ppu_pix_y < 8'(NES_H));

    always_ff @(posedge clk) begin
        if (wr_en) begin
            line_buf[{ppu_pix_y[0], ppu_pix_x}] <= ppu_color;
        end
        if (pix_tick) begin
            rd_data <= line_buf[rd_addr];
        end
    end

    // ---------------- stage 2: palette ----------------
    rgb_t lut_rgb;

    nes_rgb_lut u_lut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pix_tick  (pix_tick),
        .color_idx (rd_data),
        .rgb       (lut_rgb)
    );

    // ---------------- flag delay line ----------------
    // dark = blanked or in a side border; forces RGB to black at the pins.
    logic [1:0] hs_d;
    logic [1:0] vs_d;
    logic [1:0] blank_d;
    logic [1:0] dark_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_d    <= 2'b11;
            vs_d    <= 2'b11;
            blank_d <= 2'b11;
            dark_d  <= 2'b11;
        end else if (pix_tick) begin
            hs_d    <= {hs_d[0], hs_pre};
            vs_d    <= {vs_d[0], vs_pre};
            blank_d <= {blank_d[0], !active};
            dark_d  <= {dark_d[0], !(active && in_pic)};
        end
    end

    assign vga_hs    = hs_d[1];
    assign vga_vs    = vs_d[1];
    assign vga_blank = blank_d[1];
    assign vga_r     = dark_d[1] ? 8'd0 : lut_rgb.r;
    assign vga_g     = dark_d[1] ? 8'd0 : lut_rgb.g;
    assign vga_b     = dark_d[1] ? 8'd0 : lut_rgb.b;

    // ---------------- PPU strobes ----------------
    // Each even VGA line asks for the NES line displayed two VGA lines later,
    // i.e. the one landing in the buffer that has just finished display.
    // The last line of the frame asks for NES line 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_req    <= 1'b0;
            line_req_y  <= '0;
            frame_start <= 1'b0;
        end else begin
            line_req    <= 1'b0;
            frame_start <= 1'b0;
            if (pix_tick) begin
                frame_start <= h_last && v_last;
                if (h_cnt == 10'd0) begin
                    if (!v_cnt[0] && (v_cnt < 10'(V_VIS - 2))) begin
                        line_req   <= 1'b1;
                        line_req_y <= v_cnt[8:1] + 8'd1;
                    end else if (v_last) begin
                        line_req   <= 1'b1;
                        line_req_y <= 8'd0;
                    end
                end
            end
        end
    end

endmodule
